// File: rtl/plru_fill_pkg.sv
// plru_fill_pkg: shared types and helpers for the PLRU fill controller.
//   state_e       - controller FSM state encoding
//   MAX_ENTRIES   - upper bound on ENTRIES supported by lowest_set_oh
//   lowest_set_oh - one-hot of the lowest set bit of a vector (zero in, zero out)
package plru_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL_REQ,
    REFILL_WAIT,
    RESP
  } state_e;

  localparam int unsigned MAX_ENTRIES = 64;

  // Callers size-cast in and out, so one function serves any ENTRIES <= MAX_ENTRIES.
  function automatic logic [MAX_ENTRIES-1:0] lowest_set_oh(input logic [MAX_ENTRIES-1:0] v);
    logic [MAX_ENTRIES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
      if (v[i] && (r == '0)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_fill_match.sv
// plru_fill_match: parallel tag compare across all store entries.
// Ports:
//   valid   - per-entry valid bits
//   tags    - per-entry stored tags
//   tag     - tag being looked up
//   hit     - at least one valid entry matches
//   hit_oh  - one-hot of the matching entry (lowest index when several match)
//   inv_oh  - one-hot of the lowest invalid entry (zero when all are valid)
//   any_inv - at least one entry is invalid
module plru_fill_match
  import plru_fill_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 20
) (
  input  logic [ENTRIES-1:0]            valid,
  input  logic [ENTRIES-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]              tag,
  output logic                          hit,
  output logic [ENTRIES-1:0]            hit_oh,
  output logic [ENTRIES-1:0]            inv_oh,
  output logic                          any_inv
);

  logic [ENTRIES-1:0] match;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      match[i] = valid[i] && (tags[i] == tag);
    end
  end

  assign hit     = |match;
  assign hit_oh  = ENTRIES'(lowest_set_oh(MAX_ENTRIES'(match)));
  assign inv_oh  = ENTRIES'(lowest_set_oh(MAX_ENTRIES'(~valid)));
  assign any_inv = ~&valid;

endmodule

// File: rtl/plru_fill_ctrl.sv
// plru_fill_ctrl: lookup / refill controller for a small fully associative
// tag/data store, paired with an external PLRU replacement tree.
// Ports:
//   clk_i, rst_ni             - clock, synchronous active-low reset
//   flush_i                   - invalidate all entries
//   lookup_*                  - lookup request (valid/ready/tag)
//   rsp_*                     - response (valid/ready/data/hit/err)
//   refill_req_*              - refill request to backing store (valid/ready/tag)
//   refill_rsp_*              - refill response (valid/data/err), no back-pressure
//   used_o                    - one-hot entry-used pulse to the PLRU tree
//   plru_i                    - one-hot LRU victim from the PLRU tree
//   hit_cnt_o, miss_cnt_o     - saturating lookup counters (PLRU_FILL_PERF_CNT_EN only)
// Build option: define PLRU_FILL_PERF_CNT_EN to add the hit/miss counters.
module plru_fill_ctrl
  import plru_fill_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 20,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               lookup_valid_i,
  output logic               lookup_ready_o,
  input  logic [TAG_W-1:0]   lookup_tag_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DATA_W-1:0]  rsp_data_o,
  output logic               rsp_hit_o,
  output logic               rsp_err_o,
  output logic               refill_req_valid_o,
  input  logic               refill_req_ready_i,
  output logic [TAG_W-1:0]   refill_req_tag_o,
  input  logic               refill_rsp_valid_i,
  input  logic [DATA_W-1:0]  refill_rsp_data_i,
  input  logic               refill_rsp_err_i,
`ifdef PLRU_FILL_PERF_CNT_EN
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o,
`endif
  output logic [ENTRIES-1:0] used_o,
  input  logic [ENTRIES-1:0] plru_i
);

  state_e state_q, state_d;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][DATA_W-1:0] data_q;

  logic [TAG_W-1:0]  req_tag_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_hit_q;
  logic              rsp_err_q;

  logic               hit;
  logic [ENTRIES-1:0] hit_oh;
  logic [ENTRIES-1:0] inv_oh;
  logic               any_inv;
  logic [ENTRIES-1:0] victim_oh;
  logic [DATA_W-1:0]  hit_data;
  logic               lookup_fire;
  logic               fill_evt;
  logic               fill_we;

  plru_fill_match #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W)
  ) u_match (
    .valid   (valid_q),
    .tags    (tag_q),
    .tag     (lookup_tag_i),
    .hit     (hit),
    .hit_oh  (hit_oh),
    .inv_oh  (inv_oh),
    .any_inv (any_inv)
  );

  assign lookup_ready_o     = (state_q == IDLE) && !flush_i;
  assign lookup_fire        = lookup_valid_i && lookup_ready_o;
  assign fill_evt           = (state_q == REFILL_WAIT) && refill_rsp_valid_i;
  assign fill_we            = fill_evt && !refill_rsp_err_i;
  assign rsp_valid_o        = (state_q == RESP);
  assign refill_req_valid_o = (state_q == REFILL_REQ);
  assign refill_req_tag_o   = req_tag_q;
  assign rsp_data_o         = rsp_data_q;
  assign rsp_hit_o          = rsp_hit_q;
  assign rsp_err_o          = rsp_err_q;

  // Free entry first; otherwise the tree's choice, falling back to entry 0 if it is empty.
  always_comb begin
    victim_oh = '0;
    if (any_inv) begin
      victim_oh = inv_oh;
    end else if (plru_i != '0) begin
      victim_oh = ENTRIES'(lowest_set_oh(MAX_ENTRIES'(plru_i)));
    end else begin
      victim_oh[0] = 1'b1;
    end
  end

  always_comb begin
    hit_data = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (hit_oh[i]) hit_data = hit_data | data_q[i];
    end
  end

  // Flush clears everything, but a fill in the same cycle still lands.
  always_comb begin
    valid_d = flush_i ? '0 : valid_q;
    if (fill_we) valid_d = valid_d | victim_oh;
  end

  always_comb begin
    state_d = state_q;
    used_o  = '0;
    case (state_q)
      IDLE: begin
        if (lookup_fire) begin
          if (hit) begin
            used_o  = hit_oh;
            state_d = RESP;
          end else begin
            state_d = REFILL_REQ;
          end
        end
      end
      REFILL_REQ: begin
        if (refill_req_ready_i) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (refill_rsp_valid_i) begin
          if (!refill_rsp_err_i) used_o = victim_oh;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      req_tag_q  <= '0;
      rsp_data_q <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (lookup_fire) begin
        req_tag_q <= lookup_tag_i;
        if (hit) begin
          rsp_data_q <= hit_data;
          rsp_hit_q  <= 1'b1;
          rsp_err_q  <= 1'b0;
        end
      end
      if (fill_evt) begin
        rsp_data_q <= refill_rsp_data_i;
        rsp_hit_q  <= 1'b0;
        rsp_err_q  <= refill_rsp_err_i;
      end
    end
  end

  // Payload storage carries no reset; only valid_q qualifies it.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (rst_ni && fill_we && victim_oh[i]) begin
        tag_q[i]  <= req_tag_q;
        data_q[i] <= refill_rsp_data_i;
      end
    end
  end

`ifdef PLRU_FILL_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lookup_fire) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_plru_fill_ctrl.sv
// Directed self-checking bench for plru_fill_ctrl with ENTRIES=4.
module tb_plru_fill_ctrl;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned DATA_W  = 16;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               flush_i;
  logic               lookup_valid_i;
  logic               lookup_ready_o;
  logic [TAG_W-1:0]   lookup_tag_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [DATA_W-1:0]  rsp_data_o;
  logic               rsp_hit_o;
  logic               rsp_err_o;
  logic               refill_req_valid_o;
  logic               refill_req_ready_i;
  logic [TAG_W-1:0]   refill_req_tag_o;
  logic               refill_rsp_valid_i;
  logic [DATA_W-1:0]  refill_rsp_data_i;
  logic               refill_rsp_err_i;
  logic [ENTRIES-1:0] used_o;
  logic [ENTRIES-1:0] plru_i;
`ifdef PLRU_FILL_PERF_CNT_EN
  logic [31:0]        hit_cnt_o;
  logic [31:0]        miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              to;
    logic [3:0]        used_acc;
    logic [3:0]        used_next;
    logic [3:0]        used_fill;
    logic              req_seen;
    logic [7:0]        req_tag;
    logic              rvld;
    logic              rhit;
    logic              rerr;
    logic [15:0]       rdata;
  } res_t;

  plru_fill_ctrl #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .lookup_valid_i     (lookup_valid_i),
    .lookup_ready_o     (lookup_ready_o),
    .lookup_tag_i       (lookup_tag_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_data_o         (rsp_data_o),
    .rsp_hit_o          (rsp_hit_o),
    .rsp_err_o          (rsp_err_o),
    .refill_req_valid_o (refill_req_valid_o),
    .refill_req_ready_i (refill_req_ready_i),
    .refill_req_tag_o   (refill_req_tag_o),
    .refill_rsp_valid_i (refill_rsp_valid_i),
    .refill_rsp_data_i  (refill_rsp_data_i),
    .refill_rsp_err_i   (refill_rsp_err_i),
`ifdef PLRU_FILL_PERF_CNT_EN
    .hit_cnt_o          (hit_cnt_o),
    .miss_cnt_o         (miss_cnt_o),
`endif
    .used_o             (used_o),
    .plru_i             (plru_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni             = 1'b0;
    flush_i            = 1'b0;
    lookup_valid_i     = 1'b0;
    lookup_tag_i       = '0;
    rsp_ready_i        = 1'b0;
    refill_req_ready_i = 1'b0;
    refill_rsp_valid_i = 1'b0;
    refill_rsp_data_i  = '0;
    refill_rsp_err_i   = 1'b0;
    plru_i             = '0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // Drives one full lookup transaction; refill handshakes complete immediately.
  task automatic run_lookup(input logic [7:0] tag, input logic [15:0] rdata,
                            input logic rerr, input logic [3:0] plru,
                            input logic flush_at_fill, output res_t r);
    r.to = 1'b0;
    r.used_fill = '0;
    r.req_seen = 1'b0;
    r.req_tag = '0;
    lookup_valid_i = 1'b1;
    lookup_tag_i   = tag;
    #1;
    if (!lookup_ready_o) r.to = 1'b1;
    r.used_acc = used_o;
    tick();
    lookup_valid_i = 1'b0;
    #1;
    r.used_next = used_o;
    if (!rsp_valid_o) begin
      if (!refill_req_valid_o) r.to = 1'b1;
      r.req_seen = refill_req_valid_o;
      r.req_tag  = refill_req_tag_o;
      refill_req_ready_i = 1'b1;
      tick();
      refill_req_ready_i = 1'b0;
      refill_rsp_valid_i = 1'b1;
      refill_rsp_data_i  = rdata;
      refill_rsp_err_i   = rerr;
      plru_i             = plru;
      flush_i            = flush_at_fill;
      #1;
      r.used_fill = used_o;
      tick();
      refill_rsp_valid_i = 1'b0;
      refill_rsp_err_i   = 1'b0;
      flush_i            = 1'b0;
      plru_i             = '0;
      #1;
    end
    r.rvld  = rsp_valid_o;
    r.rhit  = rsp_hit_o;
    r.rerr  = rsp_err_o;
    r.rdata = rsp_data_o;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", lookup_ready_o); end
    checks++;
    if (rsp_valid_o !== 1'b0 || refill_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valids: rsp_valid=%b req_valid=%b want 0 0", rsp_valid_o, refill_req_valid_o);
    end
    checks++;
    if (used_o !== 4'b0000) begin errors++; $display("FAIL reset_used: got %b want 0000", used_o); end
    checks++;
    if (rsp_data_o !== 16'h0 || rsp_hit_o !== 1'b0 || rsp_err_o !== 1'b0 || refill_req_tag_o !== 8'h0) begin
      errors++; $display("FAIL reset_regs: data=%h hit=%b err=%b tag=%h want 0", rsp_data_o, rsp_hit_o, rsp_err_o, refill_req_tag_o);
    end
    tick();
  endtask

  task automatic test_miss_fill();
    res_t r;
    run_lookup(8'h05, 16'h00A5, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.to !== 1'b0 || r.req_seen !== 1'b1) begin errors++; $display("FAIL miss_req: to=%b req=%b want 0 1", r.to, r.req_seen); end
    checks++;
    if (r.req_tag !== 8'h05) begin errors++; $display("FAIL miss_req_tag: got %h want 05", r.req_tag); end
    checks++;
    if (r.used_acc !== 4'b0000) begin errors++; $display("FAIL miss_used_accept: got %b want 0000", r.used_acc); end
    checks++;
    if (r.used_fill !== 4'b0001) begin errors++; $display("FAIL miss_used_fill: got %b want 0001", r.used_fill); end
    checks++;
    if (r.rvld !== 1'b1 || r.rhit !== 1'b0 || r.rerr !== 1'b0 || r.rdata !== 16'h00A5) begin
      errors++; $display("FAIL miss_rsp: vld=%b hit=%b err=%b data=%h want 1 0 0 00a5", r.rvld, r.rhit, r.rerr, r.rdata);
    end
  endtask

  task automatic test_hit_back_to_back();
    res_t r;
    #1;
    checks++;
    if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", lookup_ready_o); end
    run_lookup(8'h05, 16'hDEAD, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.to !== 1'b0 || r.req_seen !== 1'b0) begin errors++; $display("FAIL hit_noreq: to=%b req=%b want 0 0", r.to, r.req_seen); end
    checks++;
    if (r.used_acc !== 4'b0001 || r.used_next !== 4'b0000) begin
      errors++; $display("FAIL hit_used_pulse: accept=%b next=%b want 0001 0000", r.used_acc, r.used_next);
    end
    checks++;
    if (r.rvld !== 1'b1 || r.rhit !== 1'b1 || r.rerr !== 1'b0 || r.rdata !== 16'h00A5) begin
      errors++; $display("FAIL hit_rsp: vld=%b hit=%b err=%b data=%h want 1 1 0 00a5", r.rvld, r.rhit, r.rerr, r.rdata);
    end
  endtask

  task automatic test_plru_replace();
    res_t r;
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_lookup(8'(i + 1), 16'((i + 1) * 16'h11), 1'b0, 4'b0000, 1'b0, r);
      exp = 4'b0001 << i;
      checks++;
      if (r.req_seen !== 1'b1 || r.used_fill !== exp) begin
        errors++; $display("FAIL fill_seq%0d: req=%b used=%b want 1 %b", i, r.req_seen, r.used_fill, exp);
      end
    end
    run_lookup(8'h09, 16'h0099, 1'b0, 4'b0100, 1'b0, r);
    checks++;
    if (r.req_seen !== 1'b1 || r.used_fill !== 4'b0100) begin
      errors++; $display("FAIL plru_victim: req=%b used=%b want 1 0100", r.req_seen, r.used_fill);
    end
    run_lookup(8'h04, 16'h0, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.rhit !== 1'b1 || r.used_acc !== 4'b1000 || r.rdata !== 16'h0044) begin
      errors++; $display("FAIL hit_tag4: hit=%b used=%b data=%h want 1 1000 0044", r.rhit, r.used_acc, r.rdata);
    end
    run_lookup(8'h09, 16'h0, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.rhit !== 1'b1 || r.used_acc !== 4'b0100 || r.rdata !== 16'h0099) begin
      errors++; $display("FAIL hit_tag9: hit=%b used=%b data=%h want 1 0100 0099", r.rhit, r.used_acc, r.rdata);
    end
    // Tag 3 was evicted; a non-one-hot plru picks its lowest bit (entry 1).
    run_lookup(8'h03, 16'h0333, 1'b0, 4'b1010, 1'b0, r);
    checks++;
    if (r.req_seen !== 1'b1 || r.rhit !== 1'b0 || r.used_fill !== 4'b0010) begin
      errors++; $display("FAIL evicted_tag3: req=%b hit=%b used=%b want 1 0 0010", r.req_seen, r.rhit, r.used_fill);
    end
    // Tag 2 now gone too; an all-zero plru falls back to entry 0.
    run_lookup(8'h02, 16'h0222, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.req_seen !== 1'b1 || r.used_fill !== 4'b0001) begin
      errors++; $display("FAIL plru_zero: req=%b used=%b want 1 0001", r.req_seen, r.used_fill);
    end
    run_lookup(8'h03, 16'h0, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.rhit !== 1'b1 || r.used_acc !== 4'b0010 || r.rdata !== 16'h0333) begin
      errors++; $display("FAIL hit_tag3_new: hit=%b used=%b data=%h want 1 0010 0333", r.rhit, r.used_acc, r.rdata);
    end
  endtask

  task automatic test_stall_err();
    res_t r;
    do_reset();
    lookup_valid_i = 1'b1;
    lookup_tag_i   = 8'h07;
    tick();
    lookup_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (refill_req_valid_o !== 1'b1 || refill_req_tag_o !== 8'h07) begin
        errors++; $display("FAIL stall_req%0d: valid=%b tag=%h want 1 07", i, refill_req_valid_o, refill_req_tag_o);
      end
      tick();
    end
    refill_req_ready_i = 1'b1;
    tick();
    refill_req_ready_i = 1'b0;
    refill_rsp_valid_i = 1'b1;
    refill_rsp_err_i   = 1'b1;
    refill_rsp_data_i  = 16'h00EE;
    #1;
    checks++;
    if (used_o !== 4'b0000) begin errors++; $display("FAIL err_used: got %b want 0000", used_o); end
    tick();
    refill_rsp_valid_i = 1'b0;
    refill_rsp_err_i   = 1'b0;
    #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_hit_o !== 1'b0 || rsp_data_o !== 16'h00EE) begin
      errors++; $display("FAIL err_rsp: vld=%b err=%b hit=%b data=%h want 1 1 0 00ee", rsp_valid_o, rsp_err_o, rsp_hit_o, rsp_data_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    run_lookup(8'h07, 16'h0777, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.req_seen !== 1'b1 || r.used_fill !== 4'b0001 || r.rerr !== 1'b0) begin
      errors++; $display("FAIL err_nowrite: req=%b used=%b err=%b want 1 0001 0", r.req_seen, r.used_fill, r.rerr);
    end
  endtask

  task automatic test_flush();
    res_t r;
    do_reset();
    for (int i = 0; i < 4; i++) run_lookup(8'(i + 1), 16'(i), 1'b0, 4'b0000, 1'b0, r);
    flush_i = 1'b1;
    #1;
    checks++;
    if (lookup_ready_o !== 1'b0 || used_o !== 4'b0000) begin
      errors++; $display("FAIL flush_ready: ready=%b used=%b want 0 0000", lookup_ready_o, used_o);
    end
    tick();
    flush_i = 1'b0;
    run_lookup(8'h02, 16'h0202, 1'b0, 4'b1000, 1'b0, r);
    checks++;
    if (r.req_seen !== 1'b1 || r.used_fill !== 4'b0001) begin
      errors++; $display("FAIL flush_miss: req=%b used=%b want 1 0001", r.req_seen, r.used_fill);
    end
    // Flush coincident with a fill: the fill (entry 1) survives, entry 0 is cleared.
    run_lookup(8'h06, 16'h0606, 1'b0, 4'b0000, 1'b1, r);
    checks++;
    if (r.used_fill !== 4'b0010) begin errors++; $display("FAIL flush_fill_victim: got %b want 0010", r.used_fill); end
    run_lookup(8'h06, 16'h0, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.rhit !== 1'b1 || r.used_acc !== 4'b0010 || r.rdata !== 16'h0606) begin
      errors++; $display("FAIL flush_fill_wins: hit=%b used=%b data=%h want 1 0010 0606", r.rhit, r.used_acc, r.rdata);
    end
    run_lookup(8'h02, 16'h0222, 1'b0, 4'b0000, 1'b0, r);
    checks++;
    if (r.req_seen !== 1'b1 || r.used_fill !== 4'b0001) begin
      errors++; $display("FAIL flush_fill_others: req=%b used=%b want 1 0001", r.req_seen, r.used_fill);
    end
  endtask

  task automatic test_reset_in_refill();
    res_t r;
    do_reset();
    run_lookup(8'h05, 16'h0055, 1'b0, 4'b0000, 1'b0, r);
    lookup_valid_i = 1'b1;
    lookup_tag_i   = 8'h08;
    tick();
    lookup_valid_i = 1'b0;
    refill_req_ready_i = 1'b1;
    tick();
    refill_req_ready_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    refill_rsp_valid_i = 1'b1;
    refill_rsp_data_i  = 16'h0088;
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || lookup_ready_o !== 1'b1 || used_o !== 4'b0000) begin
      errors++; $display("FAIL rst_refill_state: rsp_vld=%b ready=%b used=%b want 0 1 0000", rsp_valid_o, lookup_ready_o, used_o);
    end
    tick();
    refill_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || refill_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_refill_norsp: rsp_vld=%b req_vld=%b want 0 0", rsp_valid_o, refill_req_valid_o);
    end
    run_lookup(8'h05, 16'h0555, 1'b0, 4'b0100, 1'b0, r);
    checks++;
    if (r.req_seen !== 1'b1 || r.used_fill !== 4'b0001) begin
      errors++; $display("FAIL rst_refill_cleared: req=%b used=%b want 1 0001", r.req_seen, r.used_fill);
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit_back_to_back();
    test_plru_replace();
    test_stall_err();
    test_flush();
    test_reset_in_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
